flow_pwm_ctrl: RTL and testbench

FLOW_PWM_CTRL -- requirements
Module: flow_pwm_ctrl

---
 rtl/flow_pwm_ctrl.sv | 115 +++++++++++
 tb/tb_flow_pwm_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/flow_pwm_ctrl.sv
// Soft-start PWM driver for a valve/pump: one-entry duty command buffer, per-period
// slew-limited duty ramp, and a registered PWM output aligned to period_start.
module flow_pwm_ctrl #(
    parameter int PERIOD = 1000,
    parameter int STEP   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] cmd_duty,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        PWM,
    output logic        period_start,
    output logic [15:0] cur_duty,
    output logic        busy
);

    localparam logic [15:0] PERIOD_W = 16'(PERIOD);
    localparam logic [15:0] LAST_CNT = 16'(PERIOD - 1);
    localparam logic [15:0] STEP_W   = 16'(STEP);

    // RUN is entered on the first enabled edge; that edge parks cnt at 0 so the
    // first enabled cycle is a clean period start with duty 0.
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] target;
    logic [15:0] pend_duty;
    logic        pend_valid;

    logic        accept;
    logic        boundary;
    logic        xfer;
    logic [15:0] sat_duty;
    logic [15:0] tgt_nxt;
    logic [15:0] ramp_duty;
    logic [15:0] cur_nxt;
    logic [15:0] cnt_nxt;
    logic        pend_valid_nxt;
    state_t      state_nxt;

    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
        accept         = cmd_valid && cmd_ready;
        sat_duty       = (cmd_duty > PERIOD_W) ? PERIOD_W : cmd_duty;
        boundary       = enable && (state == ST_RUN) && (cnt == LAST_CNT);
        xfer           = pend_valid && (boundary || !enable);
        tgt_nxt        = xfer ? pend_duty : target;
        pend_valid_nxt = pend_valid;
        ramp_duty      = tgt_nxt;
        cur_nxt        = cur_duty;
        cnt_nxt        = 16'd0;
        state_nxt      = enable ? ST_RUN : ST_IDLE;

        // accept needs cmd_ready, i.e. no pending entry, so it never coincides with xfer
        if (xfer)
            pend_valid_nxt = 1'b0;
        if (accept)
            pend_valid_nxt = 1'b1;

        // Slew limiter: move at most STEP toward the target, landing exactly on it.
        if (tgt_nxt > cur_duty) begin
            if ((tgt_nxt - cur_duty) > STEP_W)
                ramp_duty = cur_duty + STEP_W;
        end else if ((cur_duty - tgt_nxt) > STEP_W) begin
            ramp_duty = cur_duty - STEP_W;
        end

        if (!enable)
            cur_nxt = 16'd0;
        else if (boundary)
            cur_nxt = ramp_duty;

        if (enable && (state == ST_RUN) && (cnt != LAST_CNT))
            cnt_nxt = cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= 16'd0;
            target       <= 16'd0;
            pend_valid   <= 1'b0;
            cur_duty     <= 16'd0;
            PWM          <= 1'b0;
            period_start <= 1'b0;
            busy         <= 1'b0;
            cmd_ready    <= 1'b1;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            target       <= tgt_nxt;
            pend_valid   <= pend_valid_nxt;
            cur_duty     <= cur_nxt;
            // Outputs are registered from next-state values so PWM and period_start line up with cnt.
            PWM          <= enable && (cnt_nxt < cur_nxt);
            period_start <= enable && (cnt_nxt == 16'd0);
            busy         <= pend_valid_nxt || (cur_nxt != tgt_nxt);
            cmd_ready    <= !pend_valid_nxt;
        end
    end

    // NOTE: the pending data register has no reset; it is only ever read while pend_valid is set.
    always_ff @(posedge clk) begin
        if (accept)
            pend_duty <= sat_duty;
    end

endmodule

// File: tb/tb_flow_pwm_ctrl.sv
// Directed bench for flow_pwm_ctrl at PERIOD=10, STEP=3; expected values are hand-derived
// per-period high counts and duty steps.
module tb_flow_pwm_ctrl;

    localparam int P = 10;
    localparam int S = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_duty = 16'd0;
    logic        cmd_ready;
    logic        pwm;
    logic        period_start;
    logic [15:0] cur_duty;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flow_pwm_ctrl #(.PERIOD(P), .STEP(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cmd_duty     (cmd_duty),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .PWM          (pwm),
        .period_start (period_start),
        .cur_duty     (cur_duty),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next cycle flagged period_start, bounded to two periods.
    task automatic sync_start(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < 2 * P);
        check({tag, "_sync"}, 32'(period_start), 1);
    endtask

    // Called in a period's first cycle; observes the whole period and stops in the next first cycle.
    task automatic measure(input string tag, input int exp_duty);
        int highs = 0;
        int starts = 0;
        check({tag, "_cur"}, 32'(cur_duty), 32'(exp_duty));
        for (int i = 0; i < P; i++) begin
            highs  += int'(pwm);
            starts += int'(period_start);
            tick();
        end
        check({tag, "_highs"}, 32'(highs), 32'(exp_duty));
        check({tag, "_starts"}, 32'(starts), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_pwm", 32'(pwm), 0);
        check("rst_ps", 32'(period_start), 0);
        check("rst_cur", 32'(cur_duty), 0);
        check("rst_busy", 32'(busy), 0);

        // Enabled with no command: idle periods, PWM low
        rst = 1'b1;
        enable = 1'b1;
        tick();
        check("en_ps", 32'(period_start), 1);
        measure("idle0", 0);
        measure("idle1", 0);
        measure("idle2", 0);
        check("idle_busy", 32'(busy), 0);

        // Command 7 ramps 3, 6, 7
        cmd_duty = 16'd7;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("c7_ready", 32'(cmd_ready), 0);
        check("c7_busy", 32'(busy), 1);
        sync_start("c7");
        check("c7_ready_back", 32'(cmd_ready), 1);
        check("c7_busy_ramp", 32'(busy), 1);
        measure("c7_p1", 3);
        measure("c7_p2", 6);
        check("c7_busy_done", 32'(busy), 0);
        measure("c7_p3", 7);

        // Drop enable mid-period at duty 7, then soft restart
        repeat (3) tick();
        check("dis_pwm_before", 32'(pwm), 1);
        enable = 1'b0;
        tick();
        check("dis_pwm", 32'(pwm), 0);
        check("dis_cur", 32'(cur_duty), 0);
        check("dis_ps", 32'(period_start), 0);
        repeat (4) tick();
        check("dis_pwm_hold", 32'(pwm), 0);
        enable = 1'b1;
        tick();
        check("re_ps", 32'(period_start), 1);
        measure("re_p0", 0);
        measure("re_p1", 3);
        measure("re_p2", 6);
        measure("re_p3", 7);

        // Command 25 saturates to 10, accepted and transferred while disabled
        enable = 1'b0;
        tick();
        cmd_duty = 16'd25;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("c25_ready", 32'(cmd_ready), 0);
        tick();
        check("c25_ready_back", 32'(cmd_ready), 1);
        check("c25_busy", 32'(busy), 1);
        check("c25_cur_idle", 32'(cur_duty), 0);
        enable = 1'b1;
        tick();
        measure("c25_p0", 0);
        measure("c25_p1", 3);
        measure("c25_p2", 6);
        measure("c25_p3", 9);
        measure("c25_p4", 10);
        measure("c25_p5", 10);

        // Accept on a boundary edge transfers one boundary later; held command waits
        repeat (9) tick();
        check("bnd_ready", 32'(cmd_ready), 1);
        cmd_duty = 16'd4;
        cmd_valid = 1'b1;
        tick();
        check("bnd_ps", 32'(period_start), 1);
        check("bnd_cur", 32'(cur_duty), 10);
        check("bnd_ready_low", 32'(cmd_ready), 0);
        cmd_duty = 16'd1;
        measure("bnd_p0", 10);
        check("bnd_cur_next", 32'(cur_duty), 7);
        check("bnd_ready_back", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        check("held_ready", 32'(cmd_ready), 0);
        sync_start("held");
        measure("held_p1", 4);
        check("held_cur", 32'(cur_duty), 1);
        check("held_busy", 32'(busy), 0);

        // Reset mid-ramp with a pending command
        cmd_duty = 16'd10;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        sync_start("mr");
        check("mr_cur", 32'(cur_duty), 4);
        tick();
        cmd_duty = 16'd8;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("mr_pend", 32'(cmd_ready), 0);
        tick();
        rst = 1'b0;
        tick();
        check("mr_rst_pwm", 32'(pwm), 0);
        check("mr_rst_ps", 32'(period_start), 0);
        check("mr_rst_cur", 32'(cur_duty), 0);
        check("mr_rst_busy", 32'(busy), 0);
        check("mr_rst_ready", 32'(cmd_ready), 1);
        rst = 1'b1;
        tick();
        check("mr_ps", 32'(period_start), 1);
        measure("mr_p0", 0);
        measure("mr_p1", 0);
        measure("mr_p2", 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_ready", 32'(cmd_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
